// File: rtl/instr_reg_pkg.sv
// Shared definitions for the instruction register and its controller:
// opcode constants and the fetch phase encoding.
package instr_reg_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam int IR_W   = 16;
    localparam int ADDR_W = 13;

    // Fetch phase: waiting for the high byte or for the low byte.
    typedef enum logic {
        EXP_HI = 1'b0,
        EXP_LO = 1'b1
    } phase_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, sticking at the all-ones value instead of wrapping.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_reg.sv
// Two-byte instruction register: captures a high byte then a low byte from
// the memory bus and commits both into IR on the same edge, so opcode and
// address never show a half-fetched instruction.
module instr_reg
    import instr_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load_ir,
    input  logic [7:0]        data,
    output logic [2:0]        opcode,
    output logic [12:0]       ir_addr,
    output logic [7:0]        op_onehot,
    output logic              ir_valid,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  instr_cnt
);

    phase_e            phase;
    phase_e            phase_nxt;
    logic [7:0]        staging;
    logic [IR_W-1:0]   ir;

    logic              stage_we;
    logic              staging_clr;
    logic              commit;
    logic              valid_clr;
    logic              err_set;

    // Phase register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= EXP_HI;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Next phase and datapath strobes; ena dominates load_ir.
    always_comb begin
        phase_nxt   = phase;
        stage_we    = 1'b0;
        staging_clr = 1'b0;
        commit      = 1'b0;
        valid_clr   = 1'b0;
        err_set     = 1'b0;
        if (!ena) begin
            phase_nxt   = EXP_HI;
            staging_clr = 1'b1;
            valid_clr   = 1'b1;
        end else begin
            unique case (phase)
                EXP_HI: begin
                    if (load_ir) begin
                        stage_we  = 1'b1;
                        valid_clr = 1'b1;
                        phase_nxt = EXP_LO;
                    end
                end
                EXP_LO: begin
                    phase_nxt = EXP_HI;
                    if (load_ir) begin
                        commit = 1'b1;
                    end else begin
                        // Controller dropped the strobe mid-instruction.
                        err_set     = 1'b1;
                        staging_clr = 1'b1;
                    end
                end
                default: phase_nxt = EXP_HI;
            endcase
        end
    end

    // High-byte staging register.
    always_ff @(posedge clk) begin
        if (!rst_n || staging_clr) begin
            staging <= '0;
        end else if (stage_we) begin
            staging <= data;
        end
    end

    // Instruction register, written only when the low byte completes a fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (commit) begin
            ir <= {staging, data};
        end
    end

    // Valid flag: set on commit, cleared when a new fetch starts or run stops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_valid <= 1'b0;
        end else if (commit) begin
            ir_valid <= 1'b1;
        end else if (valid_clr) begin
            ir_valid <= 1'b0;
        end
    end

    // Sticky incomplete-fetch flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_err <= 1'b0;
        end else if (err_set) begin
            fetch_err <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (commit),
        .count (instr_cnt)
    );

    assign opcode    = ir[IR_W-1 -: 3];
    assign ir_addr   = ir[ADDR_W-1:0];
    assign op_onehot = 8'(1) << opcode;

endmodule

// File: tb/tb_instr_reg.sv
// Directed bench for instr_reg. Two instances share all inputs: the default
// 16-bit counter and a 4-bit counter used for the saturation scenario.
module tb_instr_reg;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        load_ir;
    logic [7:0]  data;

    logic [2:0]  opcode;
    logic [12:0] ir_addr;
    logic [7:0]  op_onehot;
    logic        ir_valid;
    logic        fetch_err;
    logic [15:0] instr_cnt;

    logic [2:0]  opcode4;
    logic [12:0] ir_addr4;
    logic [7:0]  op_onehot4;
    logic        ir_valid4;
    logic        fetch_err4;
    logic [3:0]  instr_cnt4;

    int checks = 0;
    int errors = 0;

    instr_reg #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load_ir   (load_ir),
        .data      (data),
        .opcode    (opcode),
        .ir_addr   (ir_addr),
        .op_onehot (op_onehot),
        .ir_valid  (ir_valid),
        .fetch_err (fetch_err),
        .instr_cnt (instr_cnt)
    );

    instr_reg #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load_ir   (load_ir),
        .data      (data),
        .opcode    (opcode4),
        .ir_addr   (ir_addr4),
        .op_onehot (op_onehot4),
        .ir_valid  (ir_valid4),
        .fetch_err (fetch_err4),
        .instr_cnt (instr_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic ld, input logic [7:0] d);
        load_ir = ld;
        data    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        step(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_ir = 1'b1;
        data    = 8'hFF;
        ena     = 1'b1;
        do_reset();
        checks++; if (opcode !== 3'b000) begin errors++; $display("FAIL reset_opcode got %h want %h", opcode, 3'b000); end
        checks++; if (ir_addr !== 13'h0000) begin errors++; $display("FAIL reset_addr got %h want %h", ir_addr, 13'h0000); end
        checks++; if (op_onehot !== 8'h01) begin errors++; $display("FAIL reset_onehot got %h want %h", op_onehot, 8'h01); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ir_valid); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", fetch_err); end
        checks++; if (instr_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", instr_cnt); end
    endtask

    task automatic test_lda();
        step(1'b1, 8'hA1);
        checks++; if (ir_valid !== 1'b0 || opcode !== 3'b000) begin errors++; $display("FAIL lda_hi_only valid %b op %h want 0 000", ir_valid, opcode); end
        step(1'b1, 8'h23);
        checks++; if (opcode !== 3'b101) begin errors++; $display("FAIL lda_opcode got %h want 5", opcode); end
        checks++; if (ir_addr !== 13'h0123) begin errors++; $display("FAIL lda_addr got %h want 0123", ir_addr); end
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL lda_valid got %b want 1", ir_valid); end
        checks++; if (instr_cnt !== 16'd1) begin errors++; $display("FAIL lda_cnt got %0d want 1", instr_cnt); end
        checks++; if (op_onehot !== 8'h20) begin errors++; $display("FAIL lda_onehot got %h want 20", op_onehot); end
    endtask

    task automatic test_atomic_update();
        step(1'b1, 8'hE0);
        step(1'b1, 8'hFF);
        checks++; if (opcode !== 3'b111 || ir_addr !== 13'h00FF || instr_cnt !== 16'd2) begin errors++; $display("FAIL jmp_commit op %h addr %h cnt %0d want 7 00ff 2", opcode, ir_addr, instr_cnt); end
        // Idle in EXP_HI holds everything.
        step(1'b0, 8'h99);
        checks++; if (ir_valid !== 1'b1 || fetch_err !== 1'b0 || opcode !== 3'b111) begin errors++; $display("FAIL idle_hold valid %b err %b op %h want 1 0 7", ir_valid, fetch_err, opcode); end
        step(1'b1, 8'h40);
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL partial_valid got %b want 0", ir_valid); end
        checks++; if (opcode !== 3'b111 || ir_addr !== 13'h00FF) begin errors++; $display("FAIL partial_ir op %h addr %h want 7 00ff", opcode, ir_addr); end
        checks++; if (op_onehot !== 8'h80) begin errors++; $display("FAIL partial_onehot got %h want 80", op_onehot); end
        step(1'b1, 8'h11);
        checks++; if (opcode !== 3'b010 || ir_addr !== 13'h0011 || ir_valid !== 1'b1 || instr_cnt !== 16'd3) begin errors++; $display("FAIL add_commit op %h addr %h valid %b cnt %0d want 2 0011 1 3", opcode, ir_addr, ir_valid, instr_cnt); end
    endtask

    task automatic test_fetch_err();
        step(1'b1, 8'h55);
        step(1'b0, 8'h00);
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", fetch_err); end
        checks++; if (opcode !== 3'b010 || ir_addr !== 13'h0011 || instr_cnt !== 16'd3 || ir_valid !== 1'b0) begin errors++; $display("FAIL err_ir op %h addr %h cnt %0d valid %b want 2 0011 3 0", opcode, ir_addr, instr_cnt, ir_valid); end
        step(1'b1, 8'h00);
        step(1'b1, 8'h07);
        checks++; if (opcode !== 3'b000 || ir_addr !== 13'h0007 || ir_valid !== 1'b1 || instr_cnt !== 16'd4) begin errors++; $display("FAIL after_err op %h addr %h valid %b cnt %0d want 0 0007 1 4", opcode, ir_addr, ir_valid, instr_cnt); end
        checks++; if (fetch_err !== 1'b1 || op_onehot !== 8'h01) begin errors++; $display("FAIL err_sticky err %b onehot %h want 1 01", fetch_err, op_onehot); end
    endtask

    task automatic test_ena_pulse();
        do_reset();
        step(1'b1, 8'hA1);
        ena = 1'b0;
        step(1'b1, 8'h23);
        ena = 1'b1;
        checks++; if (ir_valid !== 1'b0 || fetch_err !== 1'b0 || instr_cnt !== 16'd0 || opcode !== 3'b000) begin errors++; $display("FAIL ena_off valid %b err %b cnt %0d op %h want 0 0 0 0", ir_valid, fetch_err, instr_cnt, opcode); end
        // Back in EXP_HI, so this byte is a high byte: still nothing committed.
        step(1'b1, 8'h23);
        checks++; if (ir_valid !== 1'b0 || instr_cnt !== 16'd0 || fetch_err !== 1'b0) begin errors++; $display("FAIL ena_rehi valid %b cnt %0d err %b want 0 0 0", ir_valid, instr_cnt, fetch_err); end
        step(1'b1, 8'h45);
        checks++; if (opcode !== 3'b001 || ir_addr !== 13'h0345 || instr_cnt !== 16'd1 || op_onehot !== 8'h02) begin errors++; $display("FAIL ena_resume op %h addr %h cnt %0d onehot %h want 1 0345 1 02", opcode, ir_addr, instr_cnt, op_onehot); end
    endtask

    task automatic test_reset_in_lo();
        step(1'b1, 8'hC0);
        step(1'b1, 8'h01);
        step(1'b1, 8'hFF);
        rst_n = 1'b0;
        step(1'b1, 8'hEE);
        rst_n = 1'b1;
        checks++; if (opcode !== 3'b000 || ir_addr !== 13'h0000 || op_onehot !== 8'h01) begin errors++; $display("FAIL rst_lo_ir op %h addr %h onehot %h want 0 0000 01", opcode, ir_addr, op_onehot); end
        checks++; if (ir_valid !== 1'b0 || fetch_err !== 1'b0 || instr_cnt !== 16'd0) begin errors++; $display("FAIL rst_lo_ctl valid %b err %b cnt %0d want 0 0 0", ir_valid, fetch_err, instr_cnt); end
        step(1'b1, 8'h12);
        step(1'b1, 8'h34);
        checks++; if (opcode !== 3'b000 || ir_addr !== 13'h1234 || instr_cnt !== 16'd1 || fetch_err !== 1'b0) begin errors++; $display("FAIL rst_lo_next op %h addr %h cnt %0d err %b want 0 1234 1 0", opcode, ir_addr, instr_cnt, fetch_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 8'h60);
            step(1'b1, 8'(i));
        end
        checks++; if (instr_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_at15 got %h want F", instr_cnt4); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'h60);
            step(1'b1, 8'hAB);
        end
        checks++; if (instr_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_at17 got %h want F", instr_cnt4); end
        checks++; if (instr_cnt !== 16'd17) begin errors++; $display("FAIL cnt16_at17 got %0d want 17", instr_cnt); end
        checks++; if (opcode4 !== 3'b011 || ir_addr4 !== 13'h00AB || ir_valid4 !== 1'b1) begin errors++; $display("FAIL sat_ir op %h addr %h valid %b want 3 00ab 1", opcode4, ir_addr4, ir_valid4); end
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        load_ir = 1'b0;
        data    = 8'h00;
        test_reset();
        test_lda();
        test_atomic_update();
        test_fetch_err();
        test_ena_pulse();
        test_reset_in_lo();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
